// File: rtl/sdatop_pkg.sv
// rtl/sdatop_pkg.sv - shared state encoding and defaults for the sdatop serial link
package sdatop_pkg;

    localparam int DEFAULT_NBITS       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_RECV      = 2'd1;
    localparam state_t ST_WAIT_STOP = 2'd2;

endpackage

// File: rtl/sdatop_sync_edge.sv
// rtl/sdatop_sync_edge.sv - input synchronizer with previous-sample edge detect
module sdatop_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to 1 so an idle bus produces no edges when reset is released.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/sdatop_rx.sv
// rtl/sdatop_rx.sv - scl/sda serial receiver: START/STOP detect, MSB-first shift, one-hot decode
module sdatop_rx
    import sdatop_pkg::*;
#(
    parameter int NBITS       = DEFAULT_NBITS,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda,
    output logic [NBITS-1:0]      data,
    output logic                  data_vld,
    output logic                  frame_err,
    output logic                  busy,
    output logic [(2**NBITS)-1:0] outhigh
);

    localparam int                CNT_W    = $clog2(NBITS + 1);
    localparam int                OH_W     = 2 ** NBITS;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBITS - 1);

    logic scl_lvl, scl_rise, unused_scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic scl_hi, start_det, stop_det;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NBITS-1:0]   shift_q, shift_d;
    logic [NBITS-1:0]   data_q, data_d;
    logic [OH_W-1:0]    oh_q, oh_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    sdatop_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk_i  (sclk),
        .rstn_i (rst),
        .d_i    (scl),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (unused_scl_fall)
    );

    sdatop_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk_i  (sclk),
        .rstn_i (rst),
        .d_i    (sda),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    // scl high in both the current and previous sample.
    assign scl_hi    = scl_lvl & ~scl_rise;
    assign start_det = scl_hi & sda_fall;
    assign stop_det  = scl_hi & sda_rise;

    always_ff @(posedge sclk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            oh_q    <= OH_W'(1);
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            oh_q    <= oh_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_det) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (stop_det)                             state_d = ST_IDLE;
                else if (start_det)                       state_d = ST_RECV;
                else if (scl_rise && (cnt_q == CNT_LAST)) state_d = ST_WAIT_STOP;
            end
            ST_WAIT_STOP: begin
                if (stop_det || scl_rise) state_d = ST_IDLE;
                else if (start_det)       state_d = ST_RECV;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        oh_d    = oh_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ST_RECV: begin
                if (stop_det) begin
                    err_d = 1'b1;
                end else if (start_det) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (scl_rise) begin
                    shift_d = NBITS'({shift_q, sda_lvl});
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_STOP: begin
                if (stop_det) begin
                    data_d = shift_q;
                    oh_d   = OH_W'(1) << shift_q;
                    vld_d  = 1'b1;
                end else if (start_det) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (scl_rise) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign data      = data_q;
    assign outhigh   = oh_q;
    assign data_vld  = vld_q;
    assign frame_err = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sdatop_rx.sv
// tb/tb_sdatop_rx.sv - directed table plus randomized frames checked against a token-level model
module tb_sdatop_rx;

    localparam int NB = 4;

    logic          sclk = 1'b0;
    logic          rst  = 1'b0;
    logic          scl  = 1'b1;
    logic          sda  = 1'b1;
    logic [NB-1:0] data;
    logic          data_vld, frame_err, busy;
    logic [15:0]   outhigh;

    sdatop_rx #(.NBITS(NB), .SYNC_STAGES(2)) dut (
        .sclk     (sclk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .data     (data),
        .data_vld (data_vld),
        .frame_err(frame_err),
        .busy     (busy),
        .outhigh  (outhigh)
    );

    always #5 sclk = ~sclk;

    int n_vec = 0;
    int n_bad = 0;
    int both_seen = 0;
    int obs_q[$];
    int exp_q[$];

    // Observed events: data value for a good word, -1 for a frame error.
    always @(negedge sclk) begin
        if (data_vld) obs_q.push_back(int'(data));
        if (frame_err) obs_q.push_back(-1);
        if (data_vld && frame_err) both_seen++;
    end

    bit m_active;
    bit m_sda;
    int m_bits[$];
    int m_data;

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_active = 1'b0;
        m_sda    = 1'b1;
        m_data   = 0;
        m_bits.delete();
    endfunction

    function automatic void m_bit(int b);
        if (m_active) begin
            m_bits.push_back(b);
            if (m_bits.size() > NB) begin
                exp_q.push_back(-1);
                m_active = 1'b0;
            end
        end
        m_sda = (b != 0);
    endfunction

    // With scl high, START needs sda high first; from a low sda that costs one scl pulse carrying a 1.
    function automatic void m_start();
        if (!m_sda) m_bit(1);
        m_active = 1'b1;
        m_bits.delete();
        m_sda = 1'b0;
    endfunction

    // Likewise STOP needs sda low first; from a high sda that costs one scl pulse carrying a 0.
    function automatic void m_stop();
        int v;
        if (m_sda) m_bit(0);
        if (m_active) begin
            if (m_bits.size() == NB) begin
                v = 0;
                foreach (m_bits[i]) v = v * 2 + m_bits[i];
                m_data = v;
                exp_q.push_back(v);
            end else begin
                exp_q.push_back(-1);
            end
        end
        m_active = 1'b0;
        m_sda = 1'b1;
    endfunction

    task automatic hold(int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic drv_bit(bit b);
        scl = 1'b0; hold(2);
        sda = b;    hold(2);
        scl = 1'b1; hold(4);
    endtask

    task automatic drv_start();
        if (!sda) drv_bit(1'b1);
        sda = 1'b0; hold(4);
    endtask

    task automatic drv_stop();
        if (sda) drv_bit(1'b0);
        sda = 1'b1; hold(4);
    endtask

    task automatic run(string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "S":     begin m_start(); drv_start(); end
                "P":     begin m_stop();  drv_stop();  end
                "1":     begin m_bit(1);  drv_bit(1'b1); end
                default: begin m_bit(0);  drv_bit(1'b0); end
            endcase
        end
        hold(8);
    endtask

    function automatic int count_vld();
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i] >= 0) n++;
        return n;
    endfunction

    function automatic int count_err();
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i] < 0) n++;
        return n;
    endfunction

    function automatic string rbits(int n);
        string s = "";
        string one = "1";
        string zero = "0";
        for (int i = 0; i < n; i++) s = {s, ($urandom_range(0, 1) == 1) ? one : zero};
        return s;
    endfunction

    typedef struct {
        string toks;
        int    n_vld;
        int    n_err;
        int    dat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        string s;
        int    nb;

        tbl[0] = '{"S1010P",       1, 0, 10};
        tbl[1] = '{"S0000PS1110P", 2, 0, 14};
        tbl[2] = '{"S10P",         0, 1, 14};
        tbl[3] = '{"S10S0110P",    1, 0, 6};
        tbl[4] = '{"S10110P",      0, 1, 6};
        tbl[5] = '{"S1011P",       0, 1, 6};
        tbl[6] = '{"S0100P",       1, 0, 4};

        m_reset();
        rst = 1'b0; scl = 1'b1; sda = 1'b1;
        hold(3);
        check("reset_data",     int'(data),      0);
        check("reset_outhigh",  int'(outhigh),   1);
        check("reset_busy",     int'(busy),      0);
        check("reset_vld",      int'(data_vld),  0);
        check("reset_err",      int'(frame_err), 0);
        rst = 1'b1;
        hold(4);
        check("idle_quiet", obs_q.size(), 0);

        for (int i = 0; i < 7; i++) begin
            obs_q.delete();
            exp_q.delete();
            run(tbl[i].toks);
            check({"tbl_vld_", tbl[i].toks},  count_vld(),    tbl[i].n_vld);
            check({"tbl_err_", tbl[i].toks},  count_err(),    tbl[i].n_err);
            check({"tbl_data_", tbl[i].toks}, int'(data),     tbl[i].dat);
            check({"tbl_oh_", tbl[i].toks},   int'(outhigh),  1 << tbl[i].dat);
            check({"tbl_busy_", tbl[i].toks}, int'(busy),     0);
        end

        // Reset in the middle of a frame, then a clean frame afterwards.
        obs_q.delete();
        run("S10");
        check("mid_busy", int'(busy), 1);
        rst = 1'b0;
        sda = 1'b1;
        hold(2);
        check("mid_rst_busy", int'(busy),    0);
        check("mid_rst_data", int'(data),    0);
        check("mid_rst_oh",   int'(outhigh), 1);
        rst = 1'b1;
        hold(4);
        check("mid_rst_nopulse", obs_q.size(), 0);
        m_reset();
        exp_q.delete();
        run("S0010P");
        check("post_rst_count", obs_q.size(), 1);
        check("post_rst_word",  (obs_q.size() > 0) ? obs_q[0] : -99, 2);
        check("post_rst_oh",    int'(outhigh), 4);

        for (int it = 0; it < 30; it++) begin
            s = "";
            if ($urandom_range(0, 3) == 0) s = {s, rbits(1)};
            nb = ($urandom_range(0, 1) == 1) ? NB : int'($urandom_range(1, 6));
            s = {s, "S", rbits(nb)};
            if ($urandom_range(0, 4) == 0) s = {s, "S", rbits(NB)};
            s = {s, "P"};
            obs_q.delete();
            exp_q.delete();
            run(s);
            check({"rand_count_", s}, obs_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size(); k++)
                check({"rand_event_", s}, (k < obs_q.size()) ? obs_q[k] : -99, exp_q[k]);
            check({"rand_data_", s}, int'(data),    m_data);
            check({"rand_oh_", s},   int'(outhigh), 1 << m_data);
        end

        check("never_both", both_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
